// File: rtl/pc_sequencer.sv
// Registered PC sequencer with stall, relative branches and CALL/RET.
// Optional return-address stack enabled by PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
  parameter int              PC_W      = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       advance,
  input  logic                       branch_enable,
  input  logic [3:0]                 branch_type,
  input  logic [PC_W-1:0]            branch_offset,
  input  logic [1:0]                 stored_flags,
  output logic [PC_W-1:0]            pc,
  output logic                       taken,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  localparam logic [3:0] BT_JMP  = 4'b1001;
  localparam logic [3:0] BT_BRZ  = 4'b1010;
  localparam logic [3:0] BT_BRNZ = 4'b1011;
  localparam logic [3:0] BT_BRNS = 4'b1100;
  localparam logic [3:0] BT_CALL = 4'b1101;
  localparam logic [3:0] BT_RET  = 4'b1110;

  logic [PC_W-1:0] r_pc;
  logic            r_taken;

  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_rel;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_cond;
  logic            w_is_call;
  logic            w_is_ret;
  logic            w_taken;

`ifdef PC_SEQUENCER_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_unf;

  logic [PTR_W-1:0] w_rd_ptr;
  logic [PC_W-1:0]  w_ras_top;
  logic             w_ras_full;
  logic             w_ras_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_unf;

  assign w_rd_ptr    = r_wp - PTR_W'(1);
  assign w_ras_top   = r_ras[w_rd_ptr];
  assign w_ras_full  = (r_cnt == CNT_W'(RAS_DEPTH));
  assign w_ras_empty = (r_cnt == '0);
`endif

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_pc_rel = r_pc + branch_offset;

  // Decode branch type into a taken condition and CALL/RET strobes.
  always_comb begin
    w_cond    = 1'b0;
    w_is_call = 1'b0;
    w_is_ret  = 1'b0;
    case (branch_type)
      BT_JMP:  w_cond = 1'b1;
      BT_BRZ:  w_cond = stored_flags[0];
      BT_BRNZ: w_cond = ~stored_flags[0];
      BT_BRNS: w_cond = ~stored_flags[1];
      BT_CALL: begin
        w_cond    = 1'b1;
        w_is_call = 1'b1;
      end
      BT_RET: begin
        w_is_ret = 1'b1;
`ifdef PC_SEQUENCER_RAS_EN
        w_cond   = ~w_ras_empty;
`else
        w_cond   = 1'b0;
`endif
      end
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken = branch_enable & w_cond;

`ifdef PC_SEQUENCER_RAS_EN
  assign w_push = advance & branch_enable & w_is_call;
  assign w_pop  = advance & w_taken & w_is_ret;
  assign w_unf  = advance & branch_enable & w_is_ret & w_ras_empty;
`endif

  // Select the next PC: sequential, relative target or return address.
  always_comb begin
    w_pc_nxt = w_pc_inc;
    if (w_taken) begin
`ifdef PC_SEQUENCER_RAS_EN
      if (w_is_ret) w_pc_nxt = w_ras_top;
      else          w_pc_nxt = w_pc_rel;
`else
      w_pc_nxt = w_pc_rel;
`endif
    end
  end

  // PC register and one-cycle redirect indicator; stall holds the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_taken <= 1'b0;
    end else begin
      r_taken <= advance & w_taken;
      if (advance) r_pc <= w_pc_nxt;
    end
  end

`ifdef PC_SEQUENCER_RAS_EN
  // Stack storage; contents need no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (w_push) r_ras[r_wp] <= w_pc_inc;
  end

  // Circular pointer, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + PTR_W'(1);
        if (w_ras_full) r_ovf <= 1'b1;
        else            r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_pop) begin
        r_wp  <= w_rd_ptr;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_unf) r_unf <= 1'b1;
    end
  end

  assign ras_count = r_cnt;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;
`else
  assign ras_count = '0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;
`endif

  assign pc    = r_pc;
  assign taken = r_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer.
// Expectations follow PC_SEQUENCER_RAS_EN the same way the RTL does.
module tb_pc_sequencer;

  localparam logic [3:0] JMP  = 4'b1001;
  localparam logic [3:0] BRZ  = 4'b1010;
  localparam logic [3:0] BRNZ = 4'b1011;
  localparam logic [3:0] BRNS = 4'b1100;
  localparam logic [3:0] CALL = 4'b1101;
  localparam logic [3:0] RET  = 4'b1110;
  localparam logic [15:0] RPC = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        advance = 1'b0;
  logic        branch_enable = 1'b0;
  logic [3:0]  branch_type = 4'h0;
  logic [15:0] branch_offset = 16'h0;
  logic [1:0]  stored_flags = 2'b00;
  logic [15:0] pc;
  logic        taken;
  logic [2:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;

  pc_sequencer #(
    .PC_W(16), .RAS_DEPTH(4), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance),
    .branch_enable(branch_enable), .branch_type(branch_type),
    .branch_offset(branch_offset), .stored_flags(stored_flags),
    .pc(pc), .taken(taken), .ras_count(ras_count),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        tk;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_ras[$];
  logic [15:0] m_pc;
  logic        m_ovf;
  logic        m_unf;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pc  = RPC;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_ras.delete();
  endtask

  task automatic model(input logic a, input logic e, input logic [3:0] t,
                       input logic [15:0] o, input logic [1:0] f,
                       output exp_t x);
    logic        tk;
    logic [15:0] np;
    tk = 1'b0;
    np = m_pc + 16'd1;
    if (e) begin
      case (t)
        JMP, CALL: tk = 1'b1;
        BRZ:  tk = f[0];
        BRNZ: tk = ~f[0];
        BRNS: tk = ~f[1];
        default: tk = 1'b0;
      endcase
    end
    if (tk) np = m_pc + o;
`ifdef PC_SEQUENCER_RAS_EN
    if (a && e && t == CALL) begin
      if (m_ras.size() == 4) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_ras.push_back(m_pc + 16'd1);
    end
    if (e && t == RET) begin
      if (m_ras.size() > 0) begin
        tk = 1'b1;
        if (a) np = m_ras.pop_back();
      end else if (a) begin
        m_unf = 1'b1;
      end
    end
`endif
    if (a) m_pc = np;
    x.pc  = m_pc;
    x.tk  = a & tk;
    x.cnt = 3'(m_ras.size());
    x.ovf = m_ovf;
    x.unf = m_unf;
  endtask

  task automatic step(input logic a, input logic e, input logic [3:0] t,
                      input logic [15:0] o, input logic [1:0] f);
    exp_t x;
    advance       = a;
    branch_enable = e;
    branch_type   = t;
    branch_offset = o;
    stored_flags  = f;
    model(a, e, t, o, f, x);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("pc", 32'(pc), 32'(x.pc));
    chk("taken", 32'(taken), 32'(x.tk));
    chk("ras_count", 32'(ras_count), 32'(x.cnt));
    chk("ras_ovf", 32'(ras_ovf), 32'(x.ovf));
    chk("ras_unf", 32'(ras_unf), 32'(x.unf));
  endtask

  task automatic go(input logic [15:0] tgt);
    step(1'b1, 1'b1, JMP, tgt - m_pc, 2'b00);
  endtask

  initial begin
    m_reset();
    #12;
    chk("rst_pc", 32'(pc), 32'(RPC));
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_cnt", 32'(ras_count), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, JMP, 16'h0040, 2'b00);
    chk("seq_pc", 32'(pc), 32'h0103);

    go(16'h0010);
    step(1'b1, 1'b1, BRZ, 16'hFFFA, 2'b01);
    chk("brz_t_pc", 32'(pc), 32'h000A);
    chk("brz_t_tk", 32'(taken), 32'd1);
    go(16'h0010);
    step(1'b1, 1'b1, BRZ, 16'hFFFA, 2'b00);
    chk("brz_n_pc", 32'(pc), 32'h0011);
    chk("brz_n_tk", 32'(taken), 32'd0);
    step(1'b1, 1'b1, BRNZ, 16'h0004, 2'b00);
    step(1'b1, 1'b1, BRNS, 16'h0004, 2'b10);
    step(1'b1, 1'b1, BRNS, 16'h0004, 2'b01);

`ifdef PC_SEQUENCER_RAS_EN
    go(16'h0020);
    step(1'b1, 1'b1, CALL, 16'h0030, 2'b00);
    chk("call_pc", 32'(pc), 32'h0050);
    chk("call_cnt", 32'(ras_count), 32'd1);
    step(1'b1, 1'b1, RET, 16'h0000, 2'b00);
    chk("ret_pc", 32'(pc), 32'h0021);
    chk("ret_tk", 32'(taken), 32'd1);

    go(16'h0200);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, CALL, 16'h0010, 2'b00);
    chk("ovf", 32'(ras_ovf), 32'd1);
    chk("ovf_cnt", 32'(ras_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, RET, 16'h0000, 2'b00);
      chk("lifo_pc", 32'(pc), 32'(16'h0241 - 16'(i * 16)));
    end
    step(1'b1, 1'b1, RET, 16'h0000, 2'b00);
    chk("unf_pc", 32'(pc), 32'h0212);
    chk("unf_flag", 32'(ras_unf), 32'd1);
    chk("unf_tk", 32'(taken), 32'd0);
    step(1'b1, 1'b1, CALL, 16'h0100, 2'b00);
`else
    go(16'h0008);
    step(1'b1, 1'b1, CALL, 16'h0004, 2'b00);
    chk("call_pc", 32'(pc), 32'h000C);
    chk("call_cnt", 32'(ras_count), 32'd0);
    step(1'b1, 1'b1, RET, 16'h0000, 2'b00);
    chk("ret_pc", 32'(pc), 32'h000D);
    chk("ret_tk", 32'(taken), 32'd0);
`endif

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, JMP, 16'h0300, 2'b00);
    chk("stall_tk", 32'(taken), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_pc", 32'(pc), 32'(RPC));
    chk("arst_cnt", 32'(ras_count), 32'd0);
    chk("arst_ovf", 32'(ras_ovf), 32'd0);
    chk("arst_unf", 32'(ras_unf), 32'd0);
    #1;
    rst_n = 1'b1;

    go(16'hFFFF);
    step(1'b1, 1'b0, RET, 16'h0000, 2'b00);
    chk("wrap_pc", 32'(pc), 32'h0000);
    step(1'b1, 1'b1, JMP, 16'hFFFF, 2'b00);
    chk("wrap_back", 32'(pc), 32'hFFFF);

    for (int i = 0; i < 300; i++) begin
      logic [3:0]  t;
      logic [15:0] o;
      t = ($urandom_range(0, 3) == 0) ? 4'($urandom) :
          4'($urandom_range(9, 14));
      o = 16'($urandom_range(0, 64)) - 16'd32;
      step(($urandom_range(0, 4) != 0), ($urandom_range(0, 5) != 0),
           t, o, 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter sequencer for the tiny core. It replaces the purely combinational next-PC logic with a clocked PC register. It adds parametrised PC width, a stall input, and CALL/RET support backed by a return-address stack (RAS) of configurable depth. It sits between the ControlUnit (branch type, offset, enable) and instruction memory (PC address).

## Interface
- PC_W, 16: PC and offset width in bits.
- RAS_DEPTH, 4: number of RAS entries; must be a power of two, ≥2.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- advance  in  1  1 = update PC this cycle; 0 = hold all state (stall).
- branch_enable  in  1  qualifies branch_type; 0 forces sequential step.
- branch_type  in  4  JMP=1001, BRZ=1010, BRNZ=1011, BRNS=1100, CALL=1101, RET=1110; others = no branch.
- branch_offset  in  PC_W  two's-complement relative offset, already sign-extended by ControlUnit.
- stored_flags  in  2  [0] zero flag, [1] sign/overflow flag.
- pc  out  PC_W  current PC (register).
- taken  out  1  registered; 1 for one cycle after an advance that redirected the PC.
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_ovf  out  1  sticky: a CALL was made with the RAS full.
- ras_unf  out  1  sticky: a RET was made with the RAS empty.

## Operation
- Condition: JMP→1; BRZ→flags[0]; BRNZ→~flags[0]; BRNS→~flags[1]; CALL→1; RET→1 if ras_count>0, else 0; other codes→0. taken_now = branch_enable & condition.
- Next PC on advance:
  - JMP/BRZ/BRNZ/BRNS/CALL taken: pc + branch_offset.
  - RET taken: top of RAS.
  - Otherwise: pc + 1.
- All PC arithmetic is modulo 2^PC_W. Wrap-around past all-ones to 0 (and the reverse) is legal and silent.
- CALL (enable=1, advance=1): push pc+1 (modulo), then increment ras_count.
  - With the RAS full, overwrite the oldest entry (circular buffer), keep ras_count at RAS_DEPTH, and set ras_ovf.
- RET (enable=1, advance=1):
  - Non-empty RAS: pop, and decrement ras_count.
  - Empty RAS: step pc+1, leave ras_count at 0, set ras_unf; taken=0.
- advance=0: pc, RAS, ras_count, and the sticky flags all hold. taken is driven 0.
- branch_enable=0: behaves as a sequential step regardless of branch_type. No RAS activity.
- Reset (asynchronous, any time, including mid-stall): pc=RESET_PC, taken=0, ras_count=0, ras_ovf=0, ras_unf=0. RAS entry contents are don't-care. Pointers reset to 0.
- Sticky flags clear only on reset.

## Timing
- Single-cycle: inputs sampled on rising clk. The new pc is visible immediately after that edge, so the next instruction fetch uses it.
- taken, ras_count, and the flags update on the same edge as pc.
- No combinational path from inputs to any output.
- A CALL immediately followed by a RET returns the just-pushed address with no bubble. The RAS read uses the post-push state.

## Configuration
- PC_SEQUENCER_RAS_EN defined: CALL/RET and the RAS exist as described.
- Not defined:
  - No RAS storage.
  - CALL behaves as JMP (no push).
  - RET is treated as no-branch (pc+1, taken=0).
  - ras_count, ras_ovf, and ras_unf are tied to 0.

## Test plan
- Reset with RESET_PC=16'h0100, then 3 advances with branch_enable=0 → pc = 0x0100, 0x0101, 0x0102, 0x0103; taken=0 throughout.
- pc=0x0010, BRZ, offset=16'hFFFA, flags=2'b01 → pc=0x000A, taken=1. Same with flags=2'b00 → pc=0x0011, taken=0.
- pc=0x0020, CALL offset=0x0030 → pc=0x0050, ras_count=1. Then RET → pc=0x0021, ras_count=0, taken=1.
- RAS_DEPTH=4: 5 nested CALLs → ras_ovf=1, ras_count=4. Then 4 RETs return the 4 newest return addresses in LIFO order. A 5th RET → pc+1, ras_unf=1, taken=0.
- advance=0 with a JMP presented → pc, ras_count, and the flags hold; taken=0. Assert rst_n low mid-stall → outputs reset immediately, without waiting for a clk edge.
- pc=16'hFFFF, no branch → pc=0x0000. Build without PC_SEQUENCER_RAS_EN: CALL offset=4 at pc=8 → pc=12, ras_count=0. RET → pc=13.
